// File: rtl/freq_pkg.sv
// Shared types and the saturating step helper for the frequency-select front end.
package freq_pkg;

    localparam int FREQ_W = 4;

    typedef logic [FREQ_W-1:0] freq_t;
    typedef logic [FREQ_W:0]   freq_ext_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_DELAY,
        REPEAT,
        CHORD
    } step_state_e;

    localparam int BTN_UP = 0;
    localparam int BTN_DN = 1;

    // The extra top bit catches both overflow past the limit and borrow below zero.
    function automatic freq_t freq_step(input freq_t cur, input logic up, input logic dn,
                                        input freq_t max_f);
        freq_ext_t ext;
        ext = {1'b0, cur};
        if (up && !dn) begin
            ext = ext + freq_ext_t'(1);
            if (ext > {1'b0, max_f})
                ext = {1'b0, max_f};
        end else if (dn && !up) begin
            ext = ext - freq_ext_t'(1);
            if (ext[FREQ_W])
                ext = '0;
        end
        return ext[FREQ_W-1:0];
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, debounce counter, debounced level and edge pulses.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             idle_seen;
    logic             armed;

    // A rise only counts once the button has been seen released after reset,
    // so a button held through reset never produces a phantom press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            cnt       <= '0;
            level     <= 1'b0;
            rise      <= 1'b0;
            fall      <= 1'b0;
            idle_seen <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync1     <= btn;
            sync2     <= sync1;
            idle_seen <= ~sync1 & ~sync2;
            armed     <= armed | (idle_seen & ~sync1 & ~sync2);
            rise      <= 1'b0;
            fall      <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2 & armed;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/freq_select.sv
// Up/down buttons to a saturating frequency code with single-step, auto-repeat and a clear chord.
module freq_select
    import freq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_RATE     = 4,
    parameter int MAX_FREQ        = 15
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  btn_up,
    input  logic  btn_down,
    output freq_t freqValue,
    output logic  changed
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [HOLD_W-1:0] DLY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
    localparam logic [HOLD_W-1:0] RATE_LAST = HOLD_W'(REPEAT_RATE - 1);
    localparam freq_t MAX_F = freq_t'(MAX_FREQ);

    logic [1:0] raw;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
    logic [1:0] step_req;
    logic       both_low;
    logic       chord;
    freq_t      next_val;

    assign raw = {btn_down, btn_up};

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn [1:0] (
        .clk    (clk),
        .reset_n(reset_n),
        .btn    (raw),
        .level  (lvl),
        .rise   (rise),
        .fall   (fall)
    );

    assign both_low = ~|lvl;
    // Chord fires on the cycle the second button's debounced level rises.
    assign chord    = (&lvl) && (|rise);

    for (genvar b = 0; b < 2; b++) begin : g_step
        step_state_e       st;
        logic [HOLD_W-1:0] hold;

        assign step_req[b] = !fall[b] &&
                             ((st == IDLE       && rise[b])          ||
                              (st == WAIT_DELAY && hold == DLY_LAST) ||
                              (st == REPEAT     && hold == RATE_LAST));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                st   <= IDLE;
                hold <= '0;
            end else if (chord) begin
                st   <= CHORD;
                hold <= '0;
            end else begin
                case (st)
                    IDLE: begin
                        hold <= '0;
                        if (rise[b])
                            st <= WAIT_DELAY;
                    end
                    WAIT_DELAY: begin
                        if (fall[b]) begin
                            st   <= IDLE;
                            hold <= '0;
                        end else if (hold == DLY_LAST) begin
                            st   <= REPEAT;
                            hold <= '0;
                        end else begin
                            hold <= hold + HOLD_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (fall[b]) begin
                            st   <= IDLE;
                            hold <= '0;
                        end else if (hold == RATE_LAST) begin
                            hold <= '0;
                        end else begin
                            hold <= hold + HOLD_W'(1);
                        end
                    end
                    CHORD: begin
                        hold <= '0;
                        if (both_low)
                            st <= IDLE;
                    end
                    default: begin
                        st   <= IDLE;
                        hold <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        next_val = freqValue;
        if (chord)
            next_val = '0;
        else
            next_val = freq_step(freqValue, step_req[BTN_UP], step_req[BTN_DN], MAX_F);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freqValue <= '0;
            changed   <= 1'b0;
        end else begin
            freqValue <= next_val;
            changed   <= (next_val != freqValue);
        end
    end

endmodule
